// File: rtl/param_tlb.sv
// param_tlb: fully-associative TLB with a true-LRU age permutation.
// A lookup is answered one cycle later through registered outputs.
// A fill is performed in the cycle it is requested.
module param_tlb #(
    parameter int ENTRIES   = 4,
    parameter int VA_WIDTH  = 32,
    parameter int PAGE_BITS = 12,
    parameter int PPN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           lookup_valid,
    input  logic [VA_WIDTH-1:0]            vaddr,
    input  logic                           supervisor_mode,
    input  logic                           tlb_write,
    input  logic [VA_WIDTH-PAGE_BITS-1:0]  wr_vpn,
    input  logic [PPN_WIDTH-1:0]           wr_ppn,
    output logic [PPN_WIDTH+PAGE_BITS-1:0] paddr,
    output logic                           resp_valid,
    output logic                           tlb_miss
);
    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int AW    = $clog2(ENTRIES);
    localparam int PA_W  = PPN_WIDTH + PAGE_BITS;

    logic [ENTRIES-1:0]                valid;
    logic [ENTRIES-1:0][VPN_W-1:0]     vpn;
    logic [ENTRIES-1:0][PPN_WIDTH-1:0] ppn;
    logic [ENTRIES-1:0][AW-1:0]        age;

    logic [VPN_W-1:0] lk_vpn;
    logic             hit;
    logic [AW-1:0]    hit_idx;
    logic             wr_match;
    logic [AW-1:0]    wr_match_idx;
    logic             inv_found;
    logic [AW-1:0]    inv_idx;
    logic [AW-1:0]    lru_idx;
    logic [AW-1:0]    wr_idx;
    logic             do_fill;
    logic             touch_en;
    logic [AW-1:0]    touch_idx;
    logic [AW-1:0]    touch_age;

    assign lk_vpn = vaddr[VA_WIDTH-1:PAGE_BITS];

    // Associative search: lookup hit, fill-in-place match, first free slot, LRU victim.
    always_comb begin
        hit          = 1'b0;
        hit_idx      = '0;
        wr_match     = 1'b0;
        wr_match_idx = '0;
        inv_found    = 1'b0;
        inv_idx      = '0;
        lru_idx      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && vpn[i] == lk_vpn) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
            if (valid[i] && vpn[i] == wr_vpn) begin
                wr_match     = 1'b1;
                wr_match_idx = AW'(i);
            end
            if (age[i] == AW'(ENTRIES - 1))
                lru_idx = AW'(i);
        end
        // Descending scan so the lowest-index free entry wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = AW'(i);
            end
        end
    end

    // Fill victim choice and which entry (if any) becomes most-recently used.
    always_comb begin
        wr_idx    = wr_match ? wr_match_idx : (inv_found ? inv_idx : lru_idx);
        do_fill   = tlb_write && !flush;
        touch_en  = do_fill || (lookup_valid && !tlb_write && !flush && !supervisor_mode && hit);
        touch_idx = do_fill ? wr_idx : hit_idx;
        touch_age = age[touch_idx];
    end

    // Control state: valid bits, LRU ages and the registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            for (int i = 0; i < ENTRIES; i++) age[i] <= AW'(i);
            paddr      <= '0;
            resp_valid <= 1'b0;
            tlb_miss   <= 1'b0;
        end else if (flush) begin
            valid      <= '0;
            for (int i = 0; i < ENTRIES; i++) age[i] <= AW'(i);
            resp_valid <= 1'b0;
        end else begin
            // A fill in the same cycle drops the lookup.
            resp_valid <= lookup_valid && !tlb_write;
            if (tlb_write) begin
                valid[wr_idx] <= 1'b1;
            end else if (lookup_valid) begin
                if (supervisor_mode) begin
                    tlb_miss <= 1'b0;
                    paddr    <= vaddr[PA_W-1:0];
                end else if (hit) begin
                    tlb_miss <= 1'b0;
                    paddr    <= {ppn[hit_idx], vaddr[PAGE_BITS-1:0]};
                end else begin
                    tlb_miss <= 1'b1;
                    paddr    <= '0;
                end
            end
            if (touch_en) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (AW'(i) == touch_idx)
                        age[i] <= '0;
                    else if (age[i] < touch_age)
                        age[i] <= age[i] + AW'(1);
                end
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (tlb_write && !flush) begin
            vpn[wr_idx] <= wr_vpn;
            ppn[wr_idx] <= wr_ppn;
        end
    end
endmodule

// File: tb/tb_param_tlb.sv
// tb_param_tlb: random + directed stimulus, recency-list reference model, scoreboard monitor.
module tb_param_tlb;
    localparam int E  = 4;
    localparam int VA = 32;
    localparam int PB = 12;
    localparam int PW = 8;
    localparam int VW = VA - PB;
    localparam int AW = PW + PB;

    logic          clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic          lookup_valid = 1'b0, supervisor_mode = 1'b0, tlb_write = 1'b0;
    logic [VA-1:0] vaddr = '0;
    logic [VW-1:0] wr_vpn = '0;
    logic [PW-1:0] wr_ppn = '0;
    logic [AW-1:0] paddr;
    logic          resp_valid, tlb_miss;

    param_tlb #(.ENTRIES(E), .VA_WIDTH(VA), .PAGE_BITS(PB), .PPN_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .lookup_valid(lookup_valid),
        .vaddr(vaddr), .supervisor_mode(supervisor_mode), .tlb_write(tlb_write),
        .wr_vpn(wr_vpn), .wr_ppn(wr_ppn), .paddr(paddr), .resp_valid(resp_valid),
        .tlb_miss(tlb_miss)
    );

    always #5 clk = ~clk;

    typedef struct { int due; bit miss; logic [AW-1:0] pa; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int cyc = 0, n_chk = 0, n_fail = 0;
    bit last_miss = 1'b0;
    logic [AW-1:0] last_pa = '0;

    // Reference model: entry table plus recency list (front = most recently used).
    bit            m_valid[E];
    logic [VW-1:0] m_vpn[E];
    logic [PW-1:0] m_ppn[E];
    int            order[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic void m_reset();
        order.delete();
        for (int i = 0; i < E; i++) begin
            m_valid[i] = 1'b0;
            order.push_back(i);
        end
    endfunction

    function automatic int m_find(logic [VW-1:0] v);
        int k = -1;
        for (int i = 0; i < E; i++) if (m_valid[i] && m_vpn[i] == v) k = i;
        return k;
    endfunction

    function automatic void m_touch(int k);
        int pos = 0;
        for (int j = 0; j < order.size(); j++) if (order[j] == k) pos = j;
        order.delete(pos);
        order.push_front(k);
    endfunction

    function automatic void m_fill(logic [VW-1:0] v, logic [PW-1:0] p);
        int k = m_find(v);
        for (int i = 0; i < E; i++) if (k < 0 && !m_valid[i]) k = i;
        if (k < 0) k = order[E-1];
        m_valid[k] = 1'b1;
        m_vpn[k]   = v;
        m_ppn[k]   = p;
        m_touch(k);
    endfunction

    // Drive one cycle of inputs and advance the model to match.
    task automatic step(bit lk, logic [VA-1:0] va, bit sup, bit wr,
                        logic [VW-1:0] wv, logic [PW-1:0] wp, bit fl);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        lookup_valid = lk; vaddr = va; supervisor_mode = sup;
        tlb_write = wr; wr_vpn = wv; wr_ppn = wp; flush = fl;
        if (fl) begin
            m_reset();
        end else begin
            if (lk && !wr) begin
                e.due = cyc + 1;
                if (sup) begin
                    e.miss = 1'b0;
                    e.pa   = va[AW-1:0];
                end else begin
                    k = m_find(va[VA-1:PB]);
                    if (k >= 0) begin
                        e.miss = 1'b0;
                        e.pa   = {m_ppn[k], va[PB-1:0]};
                        m_touch(k);
                    end else begin
                        e.miss = 1'b1;
                        e.pa   = '0;
                    end
                end
                sb.push_back(e);
            end
            if (wr) m_fill(wv, wp);
        end
    endtask

    task automatic look(logic [VA-1:0] va);
        step(1'b1, va, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic fill(logic [VW-1:0] v, logic [PW-1:0] p);
        step(1'b0, '0, 1'b0, 1'b1, v, p, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: responses must arrive exactly when due; otherwise outputs hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp: actual resp_valid=1 required resp_valid=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("tlb_miss", {63'd0, tlb_miss}, {63'd0, mon_e.miss});
                    check("paddr", {44'd0, paddr}, {44'd0, mon_e.pa});
                    last_miss = mon_e.miss;
                    last_pa   = mon_e.pa;
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missing_resp: actual resp_valid=0 required resp_valid=1 (cycle %0d)", cyc);
                void'(sb.pop_front());
            end else begin
                check("hold_paddr", {44'd0, paddr}, {44'd0, last_pa});
                check("hold_miss", {63'd0, tlb_miss}, {63'd0, last_miss});
            end
        end
    end

    initial begin
        logic [VW-1:0] rv;
        bit            lk, wr, sup, fl;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset_tlb_miss", {63'd0, tlb_miss}, 64'd0);
        check("reset_paddr", {44'd0, paddr}, 64'd0);
        reset = 1'b0;

        // Cold miss, then fill and hit.
        look(32'h0001_2345);
        fill(20'h00012, 8'hA5);
        look(32'h0001_2345);
        idle();
        // Bypass on an empty TLB.
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, '0, 1'b0);
        // In-place refill, then three more fills must not displace it.
        fill(20'h00012, 8'hA5);
        fill(20'h00012, 8'h3C);
        look(32'h0001_2345);
        fill(20'h00001, 8'h11);
        fill(20'h00002, 8'h22);
        fill(20'h00003, 8'h33);
        look(32'h0001_2345);
        // LRU eviction order.
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        fill(20'h1, 8'h01); fill(20'h2, 8'h02); fill(20'h3, 8'h03); fill(20'h4, 8'h04);
        look(32'h0000_1ABC);
        fill(20'h5, 8'h05);
        look(32'h0000_2ABC);
        look(32'h0000_1ABC);
        look(32'h0000_5ABC);
        // Fill and lookup together: lookup dropped.
        step(1'b1, 32'h0000_3000, 1'b0, 1'b1, 20'h6, 8'h06, 1'b0);
        look(32'h0000_6FFF);
        // Flush with simultaneous lookup and fill.
        fill(20'h00012, 8'hA5);
        step(1'b1, 32'h0001_2345, 1'b0, 1'b1, 20'h7, 8'h07, 1'b1);
        look(32'h0001_2345);
        look(32'h0000_7000);
        idle();

        // Reset pulse after the request is captured: response is abandoned.
        @(posedge clk); #1;
        lookup_valid = 1'b1; vaddr = 32'h0001_2345; supervisor_mode = 1'b0;
        tlb_write = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        lookup_valid = 1'b0;
        #1;
        check("midreset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("midreset_paddr", {44'd0, paddr}, 64'd0);
        #1;
        reset = 1'b0;
        m_reset();
        sb.delete();
        last_pa = '0;
        last_miss = 1'b0;
        look(32'h0001_2345);
        fill(20'h00012, 8'h5A);
        look(32'h0001_2FFF);

        // Random traffic over a small VPN pool so hits and evictions are frequent.
        for (int n = 0; n < 600; n++) begin
            rv  = VW'($urandom_range(0, 7)) ^ 20'hA5000;
            lk  = ($urandom_range(0, 99) < 60);
            wr  = ($urandom_range(0, 99) < 30);
            sup = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 3);
            if (sup)
                step(lk, $urandom, 1'b1, wr, rv, PW'($urandom), fl);
            else
                step(lk, {VW'($urandom_range(0, 7)) ^ 20'hA5000, PB'($urandom)}, 1'b0, wr, rv, PW'($urandom), fl);
        end
        idle();
        idle();
        @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: actual pending=%0d required pending=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
